// File: rtl/vram_pkg.sv
// Shared VRAM framebuffer definitions: resolution defaults, fill sequencer states,
// the fill command record and the RGB444 pixel packing used by writer and scan-out reader.
package vram_pkg;

    localparam int          H_RES     = 160;
    localparam int          V_RES     = 120;
    localparam logic [15:0] BASE_ADDR = 16'h0000;
    localparam int          COORD_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FINISH
    } fill_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [11:0]        color;
    } fill_cmd_t;

    // One pixel per 16-bit word; the top nibble is always written as zero.
    function automatic logic [15:0] rgb444_to_word(input logic [11:0] color);
        return {4'h0, color};
    endfunction

endpackage

// File: rtl/vram_fill_clip.sv
// Combinational screen-bounds handling for a fill command.
// VRAM_FILL_CLIP_EN defined: clip to the screen; undefined: reject anything off-screen.
module vram_fill_clip
    import vram_pkg::*;
#(
    parameter int SCR_W = H_RES,
    parameter int SCR_H = V_RES
) (
    input  fill_cmd_t cmd,
    output fill_cmd_t clipped,
    output logic      reject
);

    // One extra bit so x+w cannot wrap before the compare.
    localparam int            EW    = COORD_W + 1;
    localparam logic [EW-1:0] H_LIM = EW'(SCR_W);
    localparam logic [EW-1:0] V_LIM = EW'(SCR_H);

`ifdef VRAM_FILL_CLIP_EN
    logic [EW-1:0] w_room;
    logic [EW-1:0] h_room;

    assign w_room = H_LIM - EW'(cmd.x);
    assign h_room = V_LIM - EW'(cmd.y);
    assign reject = 1'b0;

    always_comb begin
        clipped = cmd;
        if ((EW'(cmd.x) >= H_LIM) || (EW'(cmd.y) >= V_LIM)) begin
            clipped.w = '0;
            clipped.h = '0;
        end else begin
            if (EW'(cmd.w) > w_room) clipped.w = w_room[COORD_W-1:0];
            if (EW'(cmd.h) > h_room) clipped.h = h_room[COORD_W-1:0];
        end
    end
`else
    logic [EW-1:0] x_end;
    logic [EW-1:0] y_end;

    assign x_end   = EW'(cmd.x) + EW'(cmd.w);
    assign y_end   = EW'(cmd.y) + EW'(cmd.h);
    assign clipped = cmd;
    assign reject  = (x_end > H_LIM) || (y_end > V_LIM);
`endif

endmodule

// File: rtl/vram_fill_writer.sv
// Solid-colour rectangle fill into the VRAM write port, one pixel per granted cycle.
// Screen-edge handling is selected by VRAM_FILL_CLIP_EN (see vram_fill_clip).
module vram_fill_writer #(
    parameter int                COORD_W   = vram_pkg::COORD_W,
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter int                H_RES     = vram_pkg::H_RES,
    parameter int                V_RES     = vram_pkg::V_RES,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(vram_pkg::BASE_ADDR)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [COORD_W-1:0] cmd_w,
    input  logic [COORD_W-1:0] cmd_h,
    input  logic [11:0]        cmd_color,
    output logic               wr_en,
    input  logic               wr_grant,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               busy,
    output logic               done,
    output logic               err
);
    import vram_pkg::*;

    fill_state_t        state, state_nxt;
    fill_cmd_t          cmd_in, cmd_clip;
    logic               reject, zero_area;
    logic               accept, commit;
    logic               last_col, last_row;
    logic [COORD_W-1:0] col_cnt, row_cnt, w_q, h_q;
    logic [ADDR_W-1:0]  row_start, row_base, addr_q;
    logic [DATA_W-1:0]  data_q;
    logic               err_q;

    assign cmd_in = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};

    vram_fill_clip #(
        .SCR_W (H_RES),
        .SCR_H (V_RES)
    ) u_clip (
        .cmd     (cmd_in),
        .clipped (cmd_clip),
        .reject  (reject)
    );

    assign zero_area = (cmd_clip.w == '0) || (cmd_clip.h == '0);
    // The only multiply: address of the rectangle's top-left pixel, taken once per command.
    assign row_start = BASE_ADDR + ADDR_W'(cmd_clip.y) * ADDR_W'(H_RES) + ADDR_W'(cmd_clip.x);
    assign last_col  = (col_cnt == w_q - 1'b1);
    assign last_row  = (row_cnt == h_q - 1'b1);

    assign wr_addr = addr_q;
    assign wr_data = data_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (reject || zero_area) ? FINISH : FILL;
                end
            end
            FILL: begin
                busy   = 1'b1;
                wr_en  = 1'b1;
                commit = wr_grant;
                if (wr_grant && last_col && last_row) state_nxt = FINISH;
            end
            FINISH: begin
                busy      = 1'b1;
                done      = 1'b1;
                err       = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            w_q      <= '0;
            h_q      <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            row_base <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            w_q      <= cmd_clip.w;
            h_q      <= cmd_clip.h;
            col_cnt  <= '0;
            row_cnt  <= '0;
            row_base <= row_start;
            addr_q   <= row_start;
            data_q   <= DATA_W'(rgb444_to_word(cmd_clip.color));
            err_q    <= reject;
        end else if (commit) begin
            if (!last_col) begin
                col_cnt <= col_cnt + 1'b1;
                addr_q  <= addr_q + 1'b1;
            end else if (!last_row) begin
                // Row stride by addition; address stays on the last pixel once the fill ends.
                col_cnt  <= '0;
                row_cnt  <= row_cnt + 1'b1;
                row_base <= row_base + ADDR_W'(H_RES);
                addr_q   <= row_base + ADDR_W'(H_RES);
            end
        end
    end

endmodule

// File: tb/tb_vram_fill_writer.sv
// Directed bench for vram_fill_writer: a vector table of fills plus hand sequences
// for reset, timing, write-port stalls and reset in the middle of a fill.
`timescale 1ns/1ps
module tb_vram_fill_writer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [11:0] cmd_color = '0;
    logic        wr_en;
    logic        wr_grant = 1'b1;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    vram_fill_writer dut (
        .clock     (clock),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .wr_en     (wr_en),
        .wr_grant  (wr_grant),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int          x, y, w, h;
        logic [11:0] color;
        int          n, first, last, sum, err;
    } vec_t;

    // Issues one command starting at a negedge and follows it to its done pulse.
    // Cycle 1 is the first negedge after the accepting edge.
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [11:0] color, input bit stall,
                           output int n, output int first, output int last, output int sum,
                           output int bad_order, output int bad_data, output int bad_hold,
                           output int err_seen, output int first_cyc, output int done_cyc);
        int          cyc;
        int          prev;
        bit          fin;
        bit          held_v;
        logic [15:0] held_a, held_d;
        n = 0; first = -1; last = -1; sum = 0; bad_order = 0; bad_data = 0; bad_hold = 0;
        err_seen = 0; first_cyc = -1; done_cyc = -1; prev = -1; fin = 0; held_v = 0;
        held_a = '0; held_d = '0;
        cyc = 0;
        while (!cmd_ready && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        if (!cmd_ready) chk("ready_wait_timeout", 0, 1);
        cmd_x = 8'(x); cmd_y = 8'(y); cmd_w = 8'(w); cmd_h = 8'(h); cmd_color = color;
        cmd_valid = 1'b1;
        wr_grant  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        cyc = 1;
        while (!fin && cyc < 2000) begin
            if (held_v && (wr_addr !== held_a || wr_data !== held_d)) bad_hold++;
            held_v   = 0;
            wr_grant = stall ? cyc[0] : 1'b1;
            if (wr_en) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (wr_grant) begin
                    if (first < 0) first = int'(wr_addr);
                    if (int'(wr_addr) <= prev) bad_order++;
                    if (wr_data !== {4'h0, color}) bad_data++;
                    prev = int'(wr_addr);
                    last = int'(wr_addr);
                    sum += int'(wr_addr);
                    n++;
                end else begin
                    held_v = 1; held_a = wr_addr; held_d = wr_data;
                end
            end
            if (err && !done) bad_data++;
            if (done) begin
                done_cyc = cyc;
                err_seen = int'(err);
                fin = 1;
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
        wr_grant = 1'b1;
    endtask

    vec_t tbl[9];
    int   n, first, last, sum, bo, bd, bh, es, fc, dc;
    int   commits, cyc;

    initial begin
        tbl[0] = '{2,   1,   3,   2,   12'hF0A, 6,   162,   324,   1458,  0};
        tbl[1] = '{0,   0,   0,   5,   12'h123, 0,   -1,    -1,    0,     0};
        tbl[2] = '{3,   3,   5,   0,   12'h456, 0,   -1,    -1,    0,     0};
        tbl[3] = '{159, 119, 1,   1,   12'hABC, 1,   19199, 19199, 19199, 0};
        tbl[4] = '{0,   0,   160, 1,   12'h00F, 160, 0,     159,   12720, 0};
        tbl[5] = '{10,  5,   1,   4,   12'hFFF, 4,   810,   1290,  4200,  0};
`ifdef VRAM_FILL_CLIP_EN
        tbl[6] = '{158, 119, 4,   3,   12'h777, 2,   19198, 19199, 38397, 0};
        tbl[7] = '{200, 0,   1,   1,   12'h777, 0,   -1,    -1,    0,     0};
        tbl[8] = '{0,   118, 2,   5,   12'h5A5, 4,   18880, 19041, 75842, 0};
`else
        tbl[6] = '{158, 119, 4,   3,   12'h777, 0,   -1,    -1,    0,     1};
        tbl[7] = '{200, 0,   1,   1,   12'h777, 0,   -1,    -1,    0,     1};
        tbl[8] = '{0,   118, 2,   5,   12'h5A5, 0,   -1,    -1,    0,     1};
`endif

        // Reset
        repeat (3) @(negedge clock);
        chk("rst_hold_wr_en", wr_en, 0);
        clear = 1'b1;
        @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);

        // Basic fill timing
        run_cmd(2, 1, 3, 2, 12'hF0A, 0, n, first, last, sum, bo, bd, bh, es, fc, dc);
        chk("basic_n", n, 6);
        chk("basic_first_cyc", fc, 1);
        chk("basic_done_cyc", dc, 7);
        chk("basic_ready_at_done", cmd_ready, 0);
        chk("basic_busy_at_done", busy, 1);
        @(negedge clock);
        chk("basic_done_one_cycle", done, 0);
        chk("basic_ready_after", cmd_ready, 1);
        chk("basic_busy_after", busy, 0);
        chk("basic_wr_en_after", wr_en, 0);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].color, 0,
                    n, first, last, sum, bo, bd, bh, es, fc, dc);
            chk($sformatf("v%0d_count", i), n, tbl[i].n);
            chk($sformatf("v%0d_first", i), first, tbl[i].first);
            chk($sformatf("v%0d_last", i), last, tbl[i].last);
            chk($sformatf("v%0d_addrsum", i), sum, tbl[i].sum);
            chk($sformatf("v%0d_err", i), es, tbl[i].err);
            chk($sformatf("v%0d_order", i), bo, 0);
            chk($sformatf("v%0d_data", i), bd, 0);
            if (tbl[i].n == 0) chk($sformatf("v%0d_done_cyc", i), dc, 1);
        end

        // Stall: grant on odd cycles only
        run_cmd(2, 1, 3, 2, 12'hF0A, 1, n, first, last, sum, bo, bd, bh, es, fc, dc);
        chk("stall_n", n, 6);
        chk("stall_first", first, 162);
        chk("stall_last", last, 324);
        chk("stall_sum", sum, 1458);
        chk("stall_order", bo, 0);
        chk("stall_hold", bh, 0);
        chk("stall_data", bd, 0);
        chk("stall_done_cyc", dc, 12);

        // Reset mid-fill
        @(negedge clock);
        cmd_x = 8'd5; cmd_y = 8'd5; cmd_w = 8'd10; cmd_h = 8'd10; cmd_color = 12'h321;
        cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        commits = 0;
        cyc = 0;
        while (commits < 5 && cyc < 100) begin
            if (wr_en && wr_grant) commits++;
            if (commits < 5) begin
                @(negedge clock);
                cyc++;
            end
        end
        chk("midfill_commits", commits, 5);
        @(posedge clock);
        #2;
        chk("midfill_active", wr_en, 1);
        clear = 1'b0;
        #1;
        chk("midfill_wr_en_drop", wr_en, 0);
        chk("midfill_busy", busy, 0);
        chk("midfill_ready", cmd_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("midfill_no_done%0d", k), done, 0);
        end
        clear = 1'b1;
        @(negedge clock);
        chk("midfill_no_done_after", done, 0);
        run_cmd(0, 0, 1, 1, 12'h0F0, 0, n, first, last, sum, bo, bd, bh, es, fc, dc);
        chk("post_rst_n", n, 1);
        chk("post_rst_addr", first, 0);
        chk("post_rst_data", bd, 0);
        chk("post_rst_done_cyc", dc, 2);
        chk("post_rst_err", es, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
